serial_pe_seq: RTL and testbench

Sequencer that drives `serial_pe` from an instruction memory, replacing the free-running stimulus logic with synthesizable control. On `start` it:
- walks a list of 8-bit instructions, each giving a dot-product length in 32-element groups;
- streams contiguous neuron/weight element addresses with `pe_vld_i` and `pe_ctl`;
- writes each 32-bit `pe_result` into a result buffer;
- pulses `done` once every issued instruction has returned its result.

It sits between the instruction/neuron/weight SRAMs and the PE.

---
 rtl/serial_pe_pkg.sv | 18 +
 rtl/pe_beat_gen.sv | 43 ++++
 rtl/serial_pe_seq.sv | 150 +++++++++++++++
 tb/tb_serial_pe_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pe_pkg.sv
// Shared types and constants for the serial PE sequencer family.
package serial_pe_pkg;

   localparam int ITER_W       = 13;
   localparam int LANES        = 32;
   localparam int LANE_AW      = 5;
   localparam int PE_CTL_FIRST = 0;
   localparam int PE_CTL_LAST  = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_e;

endpackage

// File: rtl/pe_beat_gen.sv
// Beat counter for one dot-product instruction: tracks iter against len and
// flags the first and last beat of the instruction.
module pe_beat_gen
   import serial_pe_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] len_in,
   input  logic       adv,
   output logic [1:0] ctl,
   output logic       last_beat
);

   logic [7:0]        len_q;
   logic [ITER_W-1:0] iter_q;
   logic              last_grp;
   logic              lane_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q  <= '0;
         iter_q <= '0;
      end else if (load) begin
         len_q  <= len_in;
         iter_q <= '0;
      end else if (adv) begin
         iter_q <= iter_q + ITER_W'(1);
      end
   end

   // Upper iter bits count 32-lane groups, lower bits the lane within a group.
   assign last_grp  = (iter_q[ITER_W-1:LANE_AW] == (len_q - 8'd1));
   assign lane_end  = &iter_q[LANE_AW-1:0];
   assign last_beat = last_grp && lane_end;

   always_comb begin
      ctl = 2'b00;
      ctl[PE_CTL_FIRST] = (iter_q == '0);
      ctl[PE_CTL_LAST]  = last_beat;
   end

endmodule

// File: rtl/serial_pe_seq.sv
// Instruction-driven sequencer feeding serial_pe: streams contiguous element
// addresses per instruction and collects PE results into the result buffer.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | reading instruction idx; zero length flags err and skips
// RUN   | one PE beat per cycle for 32*len beats
// DRAIN | waiting for outstanding PE results
// DONE  | one-cycle completion pulse
module serial_pe_seq
   import serial_pe_pkg::*;
#(
   parameter int INST_AW = 2,
   parameter int RES_AW  = 2,
   parameter int ADDR_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [INST_AW:0]   inst_cnt,
   input  logic [ADDR_W-1:0]  neuron_base,
   input  logic [ADDR_W-1:0]  weight_base,
   output logic [INST_AW-1:0] inst_addr,
   input  logic [7:0]         inst_data,
   output logic [ADDR_W-1:0]  neuron_addr,
   output logic [ADDR_W-1:0]  weight_addr,
   output logic               pe_vld_i,
   output logic [1:0]         pe_ctl,
   input  logic               pe_vld_o,
   input  logic [31:0]        pe_result,
   output logic               res_wr_en,
   output logic [RES_AW-1:0]  res_wr_addr,
   output logic [31:0]        res_wr_data,
   output logic               busy,
   output logic               done,
   output logic               err
);

   seq_state_e         state_q, state_d;
   logic [INST_AW:0]   cnt_q;
   logic [INST_AW:0]   idx_q;
   logic [INST_AW:0]   issued_q;
   logic [INST_AW:0]   res_cnt_q;
   logic [RES_AW-1:0]  res_ptr_q;
   logic [ADDR_W-1:0]  n_addr_q;
   logic [ADDR_W-1:0]  w_addr_q;
   logic               err_q;

   logic               run;
   logic               fetch;
   logic               inst_ok;
   logic               accept;
   logic               more;
   logic [INST_AW:0]   idx_inc;
   logic [INST_AW:0]   res_cnt_nxt;
   logic [1:0]         beat_ctl;
   logic               beat_last;

   assign run     = (state_q == ST_RUN);
   assign fetch   = (state_q == ST_FETCH);
   assign inst_ok = (inst_data != 8'd0);
   assign accept  = (state_q == ST_IDLE) && start;
   assign idx_inc = idx_q + (INST_AW+1)'(1);
   assign more    = (idx_inc < cnt_q);

   pe_beat_gen u_beat (
      .clk       (clk),
      .rst       (rst),
      .load      (fetch && inst_ok),
      .len_in    (inst_data),
      .adv       (run),
      .ctl       (beat_ctl),
      .last_beat (beat_last)
   );

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign err         = err_q;
   assign inst_addr   = idx_q[INST_AW-1:0];
   assign neuron_addr = n_addr_q;
   assign weight_addr = w_addr_q;
   assign pe_vld_i    = run;
   assign pe_ctl      = run ? beat_ctl : 2'b00;

   assign res_wr_en   = pe_vld_o && busy;
   assign res_wr_addr = res_ptr_q;
   assign res_wr_data = pe_result;
   // A write in the compare cycle counts, so DRAIN looks at the post-write count.
   assign res_cnt_nxt = res_cnt_q + {{INST_AW{1'b0}}, res_wr_en};

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = (inst_cnt == '0) ? ST_DONE : ST_FETCH;
         ST_FETCH: begin
            if (inst_ok)   state_d = ST_RUN;
            else if (more) state_d = ST_FETCH;
            else           state_d = ST_DRAIN;
         end
         ST_RUN:   if (beat_last) state_d = more ? ST_FETCH : ST_DRAIN;
         ST_DRAIN: if (res_cnt_nxt == issued_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         issued_q  <= '0;
         res_cnt_q <= '0;
         res_ptr_q <= '0;
         n_addr_q  <= '0;
         w_addr_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q     <= inst_cnt;
            n_addr_q  <= neuron_base;
            w_addr_q  <= weight_base;
            idx_q     <= '0;
            issued_q  <= '0;
            res_cnt_q <= '0;
            res_ptr_q <= '0;
            err_q     <= 1'b0;
         end else begin
            if (fetch && !inst_ok) begin
               err_q <= 1'b1;
               idx_q <= idx_inc;
            end
            if (run) begin
               n_addr_q <= n_addr_q + ADDR_W'(1);
               w_addr_q <= w_addr_q + ADDR_W'(1);
               if (beat_last) begin
                  issued_q <= issued_q + (INST_AW+1)'(1);
                  idx_q    <= idx_inc;
               end
            end
            if (res_wr_en) begin
               res_cnt_q <= res_cnt_nxt;
               res_ptr_q <= res_ptr_q + RES_AW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_pe_seq.sv
// Directed bench for serial_pe_seq with a behavioural PE (sum of neuron+weight
// addresses per instruction) returning results after a programmable latency.
module tb_serial_pe_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  inst_cnt;
   logic [15:0] neuron_base, weight_base;
   logic [1:0]  inst_addr;
   logic [7:0]  inst_data;
   logic [15:0] neuron_addr, weight_addr;
   logic        pe_vld_i;
   logic [1:0]  pe_ctl;
   logic        pe_vld_o = 1'b0;
   logic [31:0] pe_result = '0;
   logic        res_wr_en;
   logic [1:0]  res_wr_addr;
   logic [31:0] res_wr_data;
   logic        busy, done, err;

   logic [7:0]  imem [4];
   assign inst_data = imem[inst_addr];

   serial_pe_seq #(.INST_AW(2), .RES_AW(2), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .inst_cnt(inst_cnt),
      .neuron_base(neuron_base), .weight_base(weight_base),
      .inst_addr(inst_addr), .inst_data(inst_data),
      .neuron_addr(neuron_addr), .weight_addr(weight_addr),
      .pe_vld_i(pe_vld_i), .pe_ctl(pe_ctl),
      .pe_vld_o(pe_vld_o), .pe_result(pe_result),
      .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 1;
   logic spur = 1'b0;
   logic clr_req = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int due; logic [31:0] val; } pend_t;
   pend_t pq[$];
   logic [31:0] acc = '0;

   int beats, firsts, rises, first_cyc, last_cyc, wcnt, last_wr_cyc, done_cnt, done_cyc;
   logic prev_vld;
   logic [1:0]  wr_addr [8];
   logic [31:0] wr_data [8];

   // PE model and monitors, sampled mid-cycle.
   always @(negedge clk) begin
      if (pe_vld_i) begin
         if (pe_ctl[0]) acc = 32'(neuron_addr) + 32'(weight_addr);
         else           acc = acc + 32'(neuron_addr) + 32'(weight_addr);
         if (pe_ctl[1]) pq.push_back('{due: cyc + lat, val: acc});
      end
      if (clr_req) begin
         beats = 0; firsts = 0; rises = 0; first_cyc = 0; last_cyc = 0;
         wcnt = 0; last_wr_cyc = 0; done_cnt = 0; done_cyc = 0; prev_vld = 1'b0;
      end else begin
         if (pe_vld_i) begin
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
            if (!prev_vld) rises++;
            if (pe_ctl[0]) firsts++;
         end
         prev_vld = pe_vld_i;
         if (res_wr_en) begin
            if (wcnt < 8) begin
               wr_addr[wcnt] = res_wr_addr;
               wr_data[wcnt] = res_wr_data;
            end
            wcnt++;
            last_wr_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      pe_vld_o  = spur;
      pe_result = '0;
      if (pq.size() > 0 && pq[0].due <= cyc) begin
         pe_vld_o  = 1'b1;
         pe_result = pq[0].val;
         void'(pq.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_dot(input int nb, input int n0, input int w0);
      return 32'(nb * (n0 + w0) + nb * (nb - 1));
   endfunction

   task automatic wait_done(input int budget, inout int n);
      while (done !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic run_prog(input int budget, output int n);
      clr_req = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      clr_req = 1'b0;
      n = 1;
      wait_done(budget, n);
      repeat (3) step();
   endtask

   int n;

   initial begin
      rst = 1'b1; start = 1'b0; inst_cnt = '0;
      neuron_base = '0; weight_base = '0;
      for (int i = 0; i < 4; i++) imem[i] = 8'd0;
      step(); step();
      check("rst_vld", pe_vld_i, 0);
      check("rst_ctl", pe_ctl, 0);
      check("rst_busy_done_err", {busy, done, err, res_wr_en}, 0);
      check("rst_addr", {neuron_addr, weight_addr}, 0);
      check("rst_inst_addr", inst_addr, 0);
      rst = 1'b0;
      step();

      // single instruction, latency 1
      imem[0] = 8'h01; inst_cnt = 3'd1;
      clr_req = 1'b1; start = 1'b1;
      step();
      start = 1'b0; clr_req = 1'b0;
      check("t1_busy_c1", busy, 1);
      check("t1_vld_c1", pe_vld_i, 0);
      step();
      check("t1_vld_c2", pe_vld_i, 1);
      check("t1_ctl_first", pe_ctl, 2'b01);
      check("t1_naddr_c2", neuron_addr, 0);
      repeat (31) step();
      check("t1_ctl_last", pe_ctl, 2'b10);
      check("t1_naddr_c33", neuron_addr, 31);
      check("t1_waddr_c33", weight_addr, 31);
      n = 33;
      wait_done(100, n);
      check("t1_done_cyc", n, 35);
      repeat (3) step();
      check("t1_writes", wcnt, 1);
      check("t1_wr_data", wr_data[0], exp_dot(32, 0, 0));
      check("t1_beats", beats, 32);
      check("t1_done_after_wr", done_cyc - last_wr_cyc, 1);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_busy_after", busy, 0);

      // four length-4 instructions
      for (int i = 0; i < 4; i++) imem[i] = 8'h04;
      inst_cnt = 3'd4;
      run_prog(2000, n);
      check("t2_writes", wcnt, 4);
      for (int i = 0; i < 4; i++) begin
         check("t2_wr_addr", wr_addr[i], i);
         check("t2_wr_data", wr_data[i], exp_dot(128, 128 * i, 128 * i));
      end
      check("t2_beats", beats, 512);
      check("t2_runs", rises, 4);
      check("t2_span", last_cyc - first_cyc + 1, 515);
      check("t2_final_naddr", neuron_addr, 512);

      // zero-length middle instruction
      imem[0] = 8'h02; imem[1] = 8'h00; imem[2] = 8'h01; imem[3] = 8'h00;
      inst_cnt = 3'd3; neuron_base = 16'd100; weight_base = 16'd200;
      run_prog(2000, n);
      check("t3_writes", wcnt, 2);
      check("t3_wr_data0", wr_data[0], 32'd23232);
      check("t3_wr_data1", wr_data[1], 32'd14688);
      check("t3_err", err, 1);
      check("t3_firsts", firsts, 2);
      check("t3_beats", beats, 96);
      check("t3_done_cnt", done_cnt, 1);

      // start while busy is ignored
      imem[0] = 8'h01; inst_cnt = 3'd1; neuron_base = '0; weight_base = '0;
      clr_req = 1'b1; start = 1'b1;
      step();
      start = 1'b0; clr_req = 1'b0;
      repeat (10) step();
      start = 1'b1; inst_cnt = 3'd3; neuron_base = 16'h1000;
      step();
      start = 1'b0;
      n = 12;
      wait_done(200, n);
      repeat (3) step();
      check("t4_beats", beats, 32);
      check("t4_writes", wcnt, 1);
      check("t4_wr_data", wr_data[0], exp_dot(32, 0, 0));
      check("t4_done_cnt", done_cnt, 1);
      check("t4_err_cleared", err, 0);
      check("t4_naddr", neuron_addr, 32);

      // empty program
      inst_cnt = 3'd0; neuron_base = '0;
      run_prog(10, n);
      check("t4_zero_done_lat", (n <= 2), 1);
      check("t4_zero_beats", beats, 0);
      check("t4_zero_done_cnt", done_cnt, 1);
      check("t4_zero_writes", wcnt, 0);

      // PE result while idle is not written
      spur = 1'b1;
      step();
      check("idle_pe_vld_o", pe_vld_o, 1);
      check("idle_no_write", res_wr_en, 0);
      spur = 1'b0;
      step();

      // reset mid-RUN, then a clean run from wrapping bases
      imem[0] = 8'h04; inst_cnt = 3'd1; neuron_base = 16'h0040; weight_base = 16'h0040;
      clr_req = 1'b1; start = 1'b1;
      step();
      start = 1'b0; clr_req = 1'b0;
      repeat (12) step();
      check("t5_in_run", pe_vld_i, 1);
      rst = 1'b1;
      step();
      check("t5_rst_vld_ctl", {pe_vld_i, pe_ctl}, 0);
      check("t5_rst_flags", {busy, done, err, res_wr_en}, 0);
      check("t5_rst_addr", {neuron_addr, weight_addr}, 0);
      rst = 1'b0;
      imem[0] = 8'h01; neuron_base = 16'hFFF0; weight_base = 16'd8;
      run_prog(200, n);
      check("t5_writes", wcnt, 1);
      check("t5_wr_addr", wr_addr[0], 0);
      check("t5_wr_data", wr_data[0], 32'd1049312);
      check("t5_naddr_wrap", neuron_addr, 16);
      check("t5_waddr", weight_addr, 40);

      // results returned 5 cycles late
      lat = 5;
      imem[0] = 8'h01; imem[1] = 8'h01; inst_cnt = 3'd2;
      neuron_base = '0; weight_base = '0;
      run_prog(300, n);
      check("t6_done_cyc", n, 72);
      check("t6_writes", wcnt, 2);
      check("t6_wr_data0", wr_data[0], exp_dot(32, 0, 0));
      check("t6_wr_data1", wr_data[1], exp_dot(32, 32, 32));
      check("t6_done_after_wr", done_cyc - last_wr_cyc, 1);
      check("t6_done_cnt", done_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
